// File: rtl/rram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rram_ctrl_pkg
// Brief   : Shared types and helpers for the rram controller oFIFO arbiter.
// Revision: 1.0
// ============================================================================
package rram_ctrl_pkg;

  localparam int unsigned DEFAULT_BURST_WIDTH = 3;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } ofifo_arb_state_t;

  // The BURST field encodes length minus one.
  function automatic int unsigned burst_words(input int unsigned len);
    return len + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rram_rr_arbiter
// Brief   : Combinational round-robin pick: first set request after ptr_i.
// Revision: 1.0
// ============================================================================
module rram_rr_arbiter
  import rram_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CORE = 4,
  parameter int unsigned IDX_W    = $clog2(NUM_CORE)
) (
  input  logic [NUM_CORE-1:0] req_i,
  input  logic [IDX_W-1:0]    ptr_i,
  output logic [NUM_CORE-1:0] gnt_o,
  output logic [IDX_W-1:0]    idx_o
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Scan ptr+1, ptr+2, ... wrapping, so the last owner has the lowest priority.
    for (int unsigned k = 1; k <= NUM_CORE; k++) begin
      cand     = (int'(ptr_i) + k) % NUM_CORE;
      cand_idx = IDX_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rram_ofifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rram_ofifo_arbiter
// Brief   : Round-robin, burst-locked sharing of the output data FIFO between
//           NUM_CORE rram controller cores. Optional idle-valid watchdog is
//           enabled with macro RRAM_OFIFO_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module rram_ofifo_arbiter
  import rram_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CORE       = 4,
  parameter int unsigned DATAOUT_WIDTH  = 64,
  parameter int unsigned BURST_WIDTH    = DEFAULT_BURST_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                    CLK,
  input  logic                                    reset,
  input  logic [NUM_CORE-1:0]                     req,
  input  logic [NUM_CORE-1:0][BURST_WIDTH-1:0]    burst_len,
  input  logic [NUM_CORE-1:0]                     valid,
  input  logic [NUM_CORE-1:0][DATAOUT_WIDTH-1:0]  data,
  output logic [NUM_CORE-1:0]                     ready,
  output logic [NUM_CORE-1:0]                     grant,
  output logic                                    push_n_oFIFO,
  input  logic                                    full_oFIFO,
  output logic [DATAOUT_WIDTH-1:0]                din_oFIFO,
  output logic                                    busy,
  output logic                                    timeout_err
);

  localparam int unsigned IDX_W = $clog2(NUM_CORE);

  ofifo_arb_state_t         state_q;
  logic [NUM_CORE-1:0]      grant_q;
  logic [IDX_W-1:0]         ptr_q;
  logic [BURST_WIDTH-1:0]   cnt_q;
  logic [DATAOUT_WIDTH-1:0] din_q;
  logic [DATAOUT_WIDTH-1:0] din_d;

  logic [NUM_CORE-1:0]      arb_gnt;
  logic [IDX_W-1:0]         arb_idx;
  logic                     accept;

  rram_rr_arbiter #(
    .NUM_CORE (NUM_CORE),
    .IDX_W    (IDX_W)
  ) u_rr_arbiter (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // ptr_q doubles as the owner index while in XFER.
  assign ready        = grant_q & {NUM_CORE{(state_q == XFER) && !full_oFIFO}};
  assign accept       = |(valid & ready);
  assign push_n_oFIFO = ~accept;
  assign grant        = grant_q;
  assign busy         = (state_q == XFER);

  always_comb begin
    din_d = din_q;
    if (accept) begin
      din_d = data[ptr_q];
    end
  end

  assign din_oFIFO = din_d;

`ifdef RRAM_OFIFO_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            timeout_q;
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= IDX_W'(NUM_CORE - 1);
      cnt_q     <= '0;
      din_q     <= '0;
`ifdef RRAM_OFIFO_TIMEOUT_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      din_q <= din_d;
`ifdef RRAM_OFIFO_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= XFER;
            grant_q <= arb_gnt;
            ptr_q   <= arb_idx;
            cnt_q   <= burst_len[arb_idx];
`ifdef RRAM_OFIFO_TIMEOUT_EN
            wd_q    <= '0;
`endif
          end
        end
        XFER: begin
          if (accept) begin
            if (cnt_q == '0) begin
              state_q <= IDLE;
              grant_q <= '0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
`ifdef RRAM_OFIFO_TIMEOUT_EN
          // Only cycles the owner could have pushed but did not count as idle.
          if (accept) begin
            wd_q <= '0;
          end else if (!full_oFIFO && !valid[ptr_q]) begin
            if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
              state_q   <= IDLE;
              grant_q   <= '0;
              wd_q      <= '0;
              timeout_q <= 1'b1;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
